// File: rtl/dir_selector_n.sv
// Picks which of N_CH decoder addresses drives the character ROM for the current pixel, plus glyph row/col.
// Latency: 2 clocks from pixel position to Dir/row/col/in_region; one pixel per clock.
// No backpressure: free-running pixel pipeline, inputs are consumed every cycle.
module dir_selector_n #(
  parameter int N_CH = 4,
  parameter int DIR_W = 7,
  parameter int X0 = 256,
  parameter int Y0 = 224,
  parameter int SLOT_W = 8,
  parameter int CHAR_H = 16,
  parameter logic [DIR_W-1:0] BLANK_DIR = '0,
  parameter int BLINK_LOG = 5
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [9:0]                   pixelx,
  input  logic [9:0]                   pixely,
  input  logic [N_CH*DIR_W-1:0]        dir_in,
  input  logic                         freeze,
  input  logic [N_CH-1:0]              blink_mask,
  output logic [DIR_W-1:0]             Dir,
  output logic [$clog2(CHAR_H)-1:0]    row,
  output logic [$clog2(SLOT_W)-1:0]    col,
  output logic                         in_region
);

  localparam int COL_W   = $clog2(SLOT_W);
  localparam int ROW_W   = $clog2(CHAR_H);
  localparam int SLOT_IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int DX_W    = COL_W + SLOT_IW;

  // Band limits widened to 11 bits so an end coordinate of 1024 still compares correctly.
  localparam logic [10:0] X_LO = 11'(X0);
  localparam logic [10:0] X_HI = 11'(X0 + N_CH * SLOT_W);
  localparam logic [10:0] Y_LO = 11'(Y0);
  localparam logic [10:0] Y_HI = 11'(Y0 + CHAR_H);
  localparam logic [9:0]  X0_V = 10'(X0);
  localparam logic [9:0]  Y0_V = 10'(Y0);

  logic                 frame_start;
  logic [DIR_W-1:0]     shadow [N_CH];
  logic [BLINK_LOG:0]   frame_cnt;
  logic                 phase;

  logic                 hit;
  logic [DX_W-1:0]      dx;
  logic [ROW_W-1:0]     dy;

  logic                 hit_s1;
  logic [SLOT_IW-1:0]   slot_s1;
  logic [ROW_W-1:0]     row_s1;
  logic [COL_W-1:0]     col_s1;

  assign frame_start = (pixelx == 10'd0) && (pixely == 10'd0);
  assign phase       = frame_cnt[BLINK_LOG];

  // Only the low bits of the offsets are ever used, so subtracting the low bits alone is exact.
  assign dx  = pixelx[DX_W-1:0] - X0_V[DX_W-1:0];
  assign dy  = pixely[ROW_W-1:0] - Y0_V[ROW_W-1:0];
  assign hit = ({1'b0, pixelx} >= X_LO) && ({1'b0, pixelx} < X_HI) &&
               ({1'b0, pixely} >= Y_LO) && ({1'b0, pixely} < Y_HI);

  // Shadow copy of the channel addresses, refreshed once per frame so a string never tears.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < N_CH; k++) shadow[k] <= BLANK_DIR;
    end else if (frame_start && !freeze) begin
      for (int k = 0; k < N_CH; k++) shadow[k] <= dir_in[k*DIR_W +: DIR_W];
    end
  end

  // Frame counter drives the blink phase; it counts every frame even while frozen.
  always_ff @(posedge clock) begin
    if (!reset) begin
      frame_cnt <= '0;
    end else if (frame_start) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  // Stage 1: band hit test and slot/row/col decode of the pixel position.
  always_ff @(posedge clock) begin
    if (!reset) begin
      hit_s1  <= 1'b0;
      slot_s1 <= '0;
      row_s1  <= '0;
      col_s1  <= '0;
    end else begin
      hit_s1  <= hit;
      // Slot is zeroed outside the band so the shadow index always stays in range.
      slot_s1 <= hit ? dx[COL_W +: SLOT_IW] : '0;
      row_s1  <= dy;
      col_s1  <= dx[COL_W-1:0];
    end
  end

  // Stage 2: select the shadowed address, applying band blanking and per-channel blink.
  always_ff @(posedge clock) begin
    if (!reset) begin
      Dir       <= BLANK_DIR;
      row       <= '0;
      col       <= '0;
      in_region <= 1'b0;
    end else begin
      in_region <= hit_s1;
      if (!hit_s1 || (blink_mask[slot_s1] && phase)) begin
        Dir <= BLANK_DIR;
      end else begin
        Dir <= shadow[slot_s1];
      end
      row <= hit_s1 ? row_s1 : '0;
      col <= hit_s1 ? col_s1 : '0;
    end
  end

endmodule

// File: tb/tb_dir_selector_n.sv
// Self-checking bench for dir_selector_n: directed vector table, hand-written multi-frame sequences,
// and random pixels/inputs checked each cycle against a frame-level behavioural model.
module tb_dir_selector_n;

  localparam int N  = 4;
  localparam int DW = 7;
  localparam int BL = 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [9:0]    pixelx, pixely;
  logic [27:0]   dir_in;
  logic          freeze;
  logic [3:0]    blink_mask;
  logic [6:0]    dir_o;
  logic [3:0]    row;
  logic [2:0]    col;
  logic          in_region;

  always #5 clock = ~clock;

  dir_selector_n #(
    .N_CH(N), .DIR_W(DW), .X0(256), .Y0(224), .SLOT_W(8), .CHAR_H(16),
    .BLANK_DIR(7'd0), .BLINK_LOG(BL)
  ) dut (
    .clock(clock), .reset(reset), .pixelx(pixelx), .pixely(pixely),
    .dir_in(dir_in), .freeze(freeze), .blink_mask(blink_mask),
    .Dir(dir_o), .row(row), .col(col), .in_region(in_region)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: latched addresses per slot and number of frame starts since reset.
  int m_shadow [N];
  int m_frames;
  bit p_valid;
  int p_x, p_y;
  int e_dir, e_row, e_col, e_in;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Expected output for a pixel, from the band geometry and the blink rule.
  task automatic model_pixel(input int x, input int y);
    int slot;
    bit blanked;
    if (x >= 256 && x < 256 + N*8 && y >= 224 && y < 224 + 16) begin
      slot    = (x - 256) / 8;
      blanked = blink_mask[slot] && (((m_frames / (1 << BL)) % 2) == 1);
      e_in  = 1;
      e_row = y - 224;
      e_col = (x - 256) % 8;
      e_dir = blanked ? 0 : m_shadow[slot];
    end else begin
      e_in = 0; e_row = 0; e_col = 0; e_dir = 0;
    end
  endtask

  // One clock: advance the model with the inputs being sampled, then compare outputs after the edge.
  task automatic tick();
    if (!reset) begin
      for (int k = 0; k < N; k++) m_shadow[k] = 0;
      m_frames = 0;
      p_valid  = 0;
      e_in = 0; e_row = 0; e_col = 0; e_dir = 0;
    end else begin
      if (p_valid) model_pixel(p_x, p_y);
      else begin e_in = 0; e_row = 0; e_col = 0; e_dir = 0; end
      p_valid = 1;
      p_x = int'(pixelx);
      p_y = int'(pixely);
      if (pixelx == 10'd0 && pixely == 10'd0) begin
        if (!freeze) for (int k = 0; k < N; k++) m_shadow[k] = int'(dir_in[k*DW +: DW]);
        m_frames++;
      end
    end
    @(posedge clock);
    #1;
    chk("model_dir", int'(dir_o), e_dir);
    chk("model_row", int'(row), e_row);
    chk("model_col", int'(col), e_col);
    chk("model_in_region", int'(in_region), e_in);
  endtask

  task automatic set_pix(input int x, input int y);
    pixelx = 10'(x);
    pixely = 10'(y);
  endtask

  task automatic frame_start();
    set_pix(0, 0);
    tick();
    set_pix(0, 1);
    tick();
  endtask

  // Present a pixel long enough for its own result to reach the outputs, then check Dir.
  task automatic chk_pix(input string name, input int x, input int y, input int exp_dir);
    set_pix(x, y);
    tick();
    tick();
    chk(name, int'(dir_o), exp_dir);
  endtask

  typedef struct {
    int x; int y; int dir; int row; int col; int inr;
  } vec_t;

  vec_t tv[$];

  initial begin
    vec_t v;
    reset = 1'b0; freeze = 1'b0; blink_mask = 4'b0000;
    dir_in = {7'h33, 7'h22, 7'h11, 7'h00};
    set_pix(5, 5);

    // Vector table: scan of the band row plus the edge cases around it.
    for (int x = 256; x <= 287; x++) begin
      v.x = x; v.y = 224; v.row = 0; v.col = x % 8; v.inr = 1;
      v.dir = (x < 264) ? 'h00 : (x < 272) ? 'h11 : (x < 280) ? 'h22 : 'h33;
      tv.push_back(v);
    end
    v = '{x: 288, y: 224, dir: 0,    row: 0,  col: 0, inr: 0}; tv.push_back(v);
    v = '{x: 255, y: 230, dir: 0,    row: 0,  col: 0, inr: 0}; tv.push_back(v);
    v = '{x: 260, y: 223, dir: 0,    row: 0,  col: 0, inr: 0}; tv.push_back(v);
    v = '{x: 260, y: 239, dir: 'h00, row: 15, col: 4, inr: 1}; tv.push_back(v);
    v = '{x: 260, y: 240, dir: 0,    row: 0,  col: 0, inr: 0}; tv.push_back(v);
    v = '{x: 287, y: 239, dir: 'h33, row: 15, col: 7, inr: 1}; tv.push_back(v);
    v = '{x: 266, y: 231, dir: 'h11, row: 7,  col: 2, inr: 1}; tv.push_back(v);

    // Reset state.
    tick();
    tick();
    chk("reset_dir", int'(dir_o), 0);
    chk("reset_row", int'(row), 0);
    chk("reset_col", int'(col), 0);
    chk("reset_in_region", int'(in_region), 0);
    reset = 1'b1;
    tick();

    // Latch the initial string, then walk the table.
    frame_start();
    foreach (tv[i]) begin
      set_pix(tv[i].x, tv[i].y);
      tick();
      tick();
      chk($sformatf("tv%0d_dir", i), int'(dir_o), tv[i].dir);
      chk($sformatf("tv%0d_row", i), int'(row), tv[i].row);
      chk($sformatf("tv%0d_col", i), int'(col), tv[i].col);
      chk($sformatf("tv%0d_in_region", i), int'(in_region), tv[i].inr);
    end

    // Pipeline lag: result for a new pixel appears exactly two edges later.
    set_pix(262, 224); tick();
    set_pix(270, 224); tick();
    chk("lag_dir_slot0", int'(dir_o), 'h00);
    tick();
    chk("lag_dir_slot1", int'(dir_o), 'h11);

    // Mid-frame change stays invisible until the next frame start.
    set_pix(0, 100);
    dir_in = {4{7'h55}};
    tick();
    for (int k = 0; k < N; k++) chk_pix($sformatf("midframe_old_slot%0d", k), 258 + 8*k, 230, 'h11 * k);
    frame_start();
    for (int k = 0; k < N; k++) chk_pix($sformatf("midframe_new_slot%0d", k), 258 + 8*k, 230, 'h55);

    // Freeze across a frame start holds the old string; release shows new data one frame later.
    freeze = 1'b1;
    dir_in = {7'h4d, 7'h3c, 7'h2b, 7'h1a};
    frame_start();
    for (int k = 0; k < N; k++) chk_pix($sformatf("frozen_slot%0d", k), 259 + 8*k, 228, 'h55);
    freeze = 1'b0;
    chk_pix("unfrozen_before_fs", 267, 228, 'h55);
    frame_start();
    chk_pix("unfrozen_slot0", 259, 228, 'h1a);
    chk_pix("unfrozen_slot3", 283, 228, 'h4d);

    // Blink on slot 1 over eight frames counted from reset.
    dir_in = {7'h33, 7'h22, 7'h11, 7'h00};
    blink_mask = 4'b0010;
    reset = 1'b0; tick(); reset = 1'b1; tick();
    for (int f = 1; f <= 8; f++) begin
      frame_start();
      chk_pix($sformatf("blink_f%0d_slot1", f), 265, 230,
              (f == 2 || f == 3 || f == 6 || f == 7) ? 0 : 'h11);
      chk_pix($sformatf("blink_f%0d_slot2", f), 273, 230, 'h22);
    end
    blink_mask = 4'b0000;

    // Reset for one cycle mid-band blanks outputs and clears the shadow copy.
    set_pix(276, 232); tick(); tick();
    chk("pre_reset_dir", int'(dir_o), 'h22);
    reset = 1'b0; tick(); reset = 1'b1;
    chk("midreset_dir", int'(dir_o), 0);
    chk("midreset_in_region", int'(in_region), 0);
    tick(); tick();
    chk("postreset_dir_blank", int'(dir_o), 0);
    chk("postreset_in_region", int'(in_region), 1);
    frame_start();
    chk_pix("postreset_refill", 276, 232, 'h22);

    // Random pixels, strings, freeze, blink and occasional reset against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) set_pix(0, 0);
      else set_pix(int'($urandom_range(250, 295)), int'($urandom_range(218, 245)));
      if ($urandom_range(0, 7) == 0) dir_in = 28'($urandom);
      if ($urandom_range(0, 9) == 0) freeze = 1'($urandom);
      if ($urandom_range(0, 15) == 0) blink_mask = 4'($urandom);
      reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
